imem_arbiter: RTL

Single-port access controller for the synchronous instruction memory of the pipelined RISC-V core. It shares the memory port between two requesters: the Fetch stage, which reads, and the program loader, which writes at boot and during run. The block sequences a boot phase and a run phase, returns fetched words one cycle after grant, and substitutes NOP (0x00000013) for reads killed by a pipeline flush. It sits between the IF stage / loader and the instruction memory array.

---
 rtl/imem_arbiter_if.sv | 42 ++++
 rtl/imem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundle of the Fetch, loader and memory-port signals served by imem_arbiter.
// Signal names keep the arbiter's point of view (i_* driven into the arbiter, o_* driven by it).
//   Fetch  : i_f_req, i_f_pc, i_f_flush -> o_f_gnt, o_f_rvalid, o_f_instr
//   Loader : i_l_valid, i_l_addr, i_l_wdata, i_l_done -> o_l_ready, o_l_err, o_boot
//   Memory : o_m_en, o_m_we, o_m_addr, o_m_wdata <- i_m_rdata
// Modports: slave = the arbiter, master = the surrounding requesters plus memory.
interface imem_arbiter_if #(
    parameter int unsigned DEPTH_LOG2 = 14
);
    logic                  i_f_req;
    logic [31:0]           i_f_pc;
    logic                  i_f_flush;
    logic                  o_f_gnt;
    logic                  o_f_rvalid;
    logic [31:0]           o_f_instr;

    logic                  i_l_valid;
    logic [31:0]           i_l_addr;
    logic [31:0]           i_l_wdata;
    logic                  i_l_done;
    logic                  o_l_ready;
    logic                  o_l_err;
    logic                  o_boot;

    logic                  o_m_en;
    logic                  o_m_we;
    logic [DEPTH_LOG2-1:0] o_m_addr;
    logic [31:0]           o_m_wdata;
    logic [31:0]           i_m_rdata;

    modport slave (
        input  i_f_req, i_f_pc, i_f_flush, i_l_valid, i_l_addr, i_l_wdata, i_l_done, i_m_rdata,
        output o_f_gnt, o_f_rvalid, o_f_instr, o_l_ready, o_l_err, o_boot,
        output o_m_en, o_m_we, o_m_addr, o_m_wdata
    );

    modport master (
        output i_f_req, i_f_pc, i_f_flush, i_l_valid, i_l_addr, i_l_wdata, i_l_done, i_m_rdata,
        input  o_f_gnt, o_f_rvalid, o_f_instr, o_l_ready, o_l_err, o_boot,
        input  o_m_en, o_m_we, o_m_addr, o_m_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single instruction-memory port between the Fetch stage (reads) and
// the program loader (writes). BOOT serves only the loader; an i_l_done pulse moves to RUN,
// where Fetch has fixed priority. Read data returns one cycle after grant; reads killed by a
// flush return NOP (0x00000013).
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : imem_arbiter_if.slave carrying the Fetch, loader and memory-port signals
// Optional feature: define IMEM_ARB_STARVE_EN to force a starving loader write through after
// STARVE_LIMIT consecutive lost cycles in RUN.
module imem_arbiter #(
    parameter int unsigned DEPTH_LOG2   = 14,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    imem_arbiter_if.slave bus
);
    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e state_q, state_d;
    logic   rd_pend_q, rd_kill_q;
    logic   l_err_q;
    logic   l_illegal;
    logic   starve_force;
    logic   f_gnt, l_ready;

    // PC byte-offset and out-of-range bits never reach the memory.
    logic unused_pc;
    assign unused_pc = ^{bus.i_f_pc[31:DEPTH_LOG2+2], bus.i_f_pc[1:0]};

    assign l_illegal = (bus.i_l_addr[1:0] != 2'b00) ||
                       ((bus.i_l_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RUN is left only through reset
    always_comb begin
        state_d = state_q;
        if (state_q == StBoot && bus.i_l_done) begin
            state_d = StRun;
        end
    end

    // Output logic; grants are forced low while reset is asserted
    always_comb begin
        f_gnt         = 1'b0;
        l_ready       = 1'b0;
        bus.o_m_en    = 1'b0;
        bus.o_m_we    = 1'b0;
        bus.o_m_addr  = '0;
        bus.o_m_wdata = '0;
        if (i_reset) begin
            unique case (state_q)
                StBoot: l_ready = bus.i_l_valid;
                StRun: begin
                    if (starve_force) begin
                        l_ready = 1'b1;
                    end else begin
                        f_gnt   = bus.i_f_req;
                        l_ready = bus.i_l_valid & ~bus.i_f_req;
                    end
                end
                default: ;
            endcase
        end
        if (f_gnt) begin
            bus.o_m_en   = 1'b1;
            bus.o_m_addr = bus.i_f_pc[DEPTH_LOG2+1:2];
        end else if (l_ready && !l_illegal) begin
            // Illegal writes are handshaken but never reach the array.
            bus.o_m_en    = 1'b1;
            bus.o_m_we    = 1'b1;
            bus.o_m_addr  = bus.i_l_addr[DEPTH_LOG2+1:2];
            bus.o_m_wdata = bus.i_l_wdata;
        end
    end

    assign bus.o_f_gnt   = f_gnt;
    assign bus.o_l_ready = l_ready;
    assign bus.o_boot    = (state_q == StBoot);
    assign bus.o_l_err   = l_err_q;

    // Read tracking and sticky loader error
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_pend_q <= 1'b0;
            rd_kill_q <= 1'b0;
            l_err_q   <= 1'b0;
        end else begin
            rd_pend_q <= f_gnt;
            if (f_gnt) begin
                rd_kill_q <= bus.i_f_flush;
            end
            if (l_ready && l_illegal) begin
                l_err_q <= 1'b1;
            end
        end
    end

    // A flush in the return cycle kills that return as well as the read being issued.
    assign bus.o_f_rvalid = rd_pend_q;
    assign bus.o_f_instr  = (rd_pend_q && !rd_kill_q && !bus.i_f_flush) ? bus.i_m_rdata : Nop;

`ifdef IMEM_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.i_l_valid || l_ready) begin
            starve_cnt_d = '0;
        end else if (state_q == StRun && starve_cnt_q < CntW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_force = (state_q == StRun) && bus.i_l_valid &&
                          (starve_cnt_q >= CntW'(STARVE_LIMIT));
`else
    assign starve_force = 1'b0;
`endif
endmodule
